// File: rtl/peripheral_dbg_soc_osd_uart_ahb3_host.sv
// AHB3 initiator that runs a 16550-style UART: polls LSR, drains RBR into an rx
// byte stream and pushes tx-stream bytes into THR, one non-pipelined transfer at a time.
module peripheral_dbg_soc_osd_uart_ahb3_host #(
   parameter int XLEN          = 32,
   parameter int POLL_INTERVAL = 16,
   parameter int WAIT_TIMEOUT  = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tx_valid,
   input  logic [7:0]      tx_char,
   output logic            tx_ready,
   output logic            rx_valid,
   output logic [7:0]      rx_char,
   input  logic            rx_ready,
   output logic            err,
   output logic            ahb3_hsel_o,
   output logic [15:0]     ahb3_haddr_o,
   output logic [XLEN-1:0] ahb3_hwdata_o,
   output logic            ahb3_hwrite_o,
   output logic [2:0]      ahb3_hsize_o,
   output logic [2:0]      ahb3_hburst_o,
   output logic [3:0]      ahb3_hprot_o,
   output logic [1:0]      ahb3_htrans_o,
   output logic            ahb3_hmastlock_o,
   input  logic [XLEN-1:0] ahb3_hrdata_i,
   input  logic            ahb3_hready_i,
   input  logic            ahb3_hresp_i
);

   localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
   localparam int PCW = $clog2(POLL_INTERVAL + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);
   localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_INTERVAL - 1);
   localparam logic [2:0] REG_RBR = 3'd0;
   localparam logic [2:0] REG_IER = 3'd1;
   localparam logic [2:0] REG_LSR = 3'd5;

   typedef enum logic [2:0] {S_INIT, S_POLL, S_RD_RBR, S_WR_THR, S_WAIT} state_t;

   state_t         state;
   logic           active;
   logic [WCW-1:0] wait_cnt;
   logic [PCW-1:0] poll_cnt;

   logic [2:0] launch_reg;
   logic       launch_now;
   logic       launch_write;
   logic       poll_done;
   logic       xfer_ok;
   logic       take_rx;
   logic       take_tx;
   logic       unused_rdata;

   function automatic logic [3:0] prot_enc(input logic [1:0] idx);
      case (idx)
         2'b11:   return 4'b0001;
         2'b10:   return 4'b0010;
         2'b01:   return 4'b0100;
         default: return 4'b0000;
      endcase
   endfunction

   // WAIT launches the LSR read on its last cycle, so the bus idles exactly POLL_INTERVAL cycles
   always_comb begin
      launch_reg = REG_RBR;
      case (state)
         S_INIT:         launch_reg = REG_IER;
         S_POLL, S_WAIT: launch_reg = REG_LSR;
         default:        launch_reg = REG_RBR;
      endcase
   end

   assign poll_done    = (poll_cnt == POLL_LAST);
   assign launch_now   = (state == S_WAIT) ? poll_done : !active;
   assign launch_write = (state == S_INIT) || (state == S_WR_THR);
   assign xfer_ok      = active && ahb3_hready_i && !ahb3_hresp_i;
   assign take_rx      = (state == S_POLL) && xfer_ok && ahb3_hrdata_i[0] && !rx_valid;
   assign take_tx      = (state == S_POLL) && xfer_ok && !take_rx && ahb3_hrdata_i[5] && tx_valid;

   assign tx_ready      = take_tx;
   assign ahb3_hsize_o  = 3'b000;
   assign ahb3_hburst_o = 3'b000;
   assign unused_rdata  = ^ahb3_hrdata_i[XLEN-1:8];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_INIT;
         active           <= 1'b0;
         wait_cnt         <= '0;
         poll_cnt         <= '0;
         err              <= 1'b0;
         rx_valid         <= 1'b0;
         rx_char          <= 8'h00;
         ahb3_hsel_o      <= 1'b0;
         ahb3_haddr_o     <= 16'h0000;
         ahb3_hwdata_o    <= '0;
         ahb3_hwrite_o    <= 1'b0;
         ahb3_hprot_o     <= 4'b0000;
         ahb3_htrans_o    <= 2'b00;
         ahb3_hmastlock_o <= 1'b0;
      end else begin
         err <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;

         if (launch_now) begin
            active           <= 1'b1;
            wait_cnt         <= '0;
            ahb3_hsel_o      <= 1'b1;
            ahb3_htrans_o    <= 2'b10;
            ahb3_hmastlock_o <= 1'b1;
            ahb3_haddr_o     <= {13'd0, launch_reg[2], 2'b00};
            ahb3_hwrite_o    <= launch_write;
            ahb3_hprot_o     <= prot_enc(launch_reg[1:0]);
            if (state == S_INIT) ahb3_hwdata_o <= '0;
         end

         if (state == S_WAIT) begin
            if (poll_done) begin
               poll_cnt <= '0;
               state    <= S_POLL;
            end else begin
               poll_cnt <= poll_cnt + 1'b1;
            end
         end else if (active) begin
            if (ahb3_hready_i || wait_cnt == WAIT_LAST) begin
               active           <= 1'b0;
               ahb3_hsel_o      <= 1'b0;
               ahb3_htrans_o    <= 2'b00;
               ahb3_hmastlock_o <= 1'b0;
            end
            if (ahb3_hready_i) begin
               if (ahb3_hresp_i) begin
                  err   <= 1'b1;
                  state <= S_WAIT;
               end else begin
                  case (state)
                     S_INIT: state <= S_POLL;
                     S_POLL: begin
                        if (take_rx) begin
                           state <= S_RD_RBR;
                        end else if (take_tx) begin
                           ahb3_hwdata_o <= {(XLEN/8){tx_char}};
                           state         <= S_WR_THR;
                        end else begin
                           state <= S_WAIT;
                        end
                     end
                     S_RD_RBR: begin
                        rx_char  <= ahb3_hrdata_i[7:0];
                        rx_valid <= 1'b1;
                        state    <= S_POLL;
                     end
                     default: state <= S_POLL;
                  endcase
               end
            end else if (wait_cnt == WAIT_LAST) begin
               err   <= 1'b1;
               state <= S_WAIT;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

endmodule
